// File: rtl/acorn128_state_reg.sv
// ACORN-128 293-bit state register: runs the 1792-step key/IV init, then steps on in_valid&&in_ready; one step per clock, step pulses one cycle later.
// Optional ACORN_KEY_ZEROIZE_EN clears the latched key when INIT completes; upstream is backpressured whenever not READY.
module acorn128_state_reg (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  input  logic         f_in,
  input  logic         m_in,
  input  logic         ca_in,
  input  logic         cb_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [292:0] state_out,
  output logic         ca_out,
  output logic         cb_out,
  output logic         busy,
  output logic         init_done,
  output logic         step
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] INIT  = 2'd1;
  localparam logic [1:0] READY = 2'd2;

  logic [1:0]   st;
  logic [292:0] s;
  logic [10:0]  cnt;
  logic [127:0] key_r;
  logic [127:0] iv_r;
  logic         m_bit;
  logic         do_step;
  logic [292:0] s_next;

  // Every update reads only bits that are modified later in the chain, so all taps use the registered S.
  always_comb begin
    state_out      = s;
    state_out[289] = s[289] ^ s[235] ^ s[230];
    state_out[230] = s[230] ^ s[196] ^ s[193];
    state_out[193] = s[193] ^ s[160] ^ s[154];
    state_out[154] = s[154] ^ s[111] ^ s[107];
    state_out[107] = s[107] ^ s[66]  ^ s[61];
    state_out[61]  = s[61]  ^ s[23]  ^ s[0];
  end

  always_comb begin
    m_bit = 1'b0;
    if (st == INIT) begin
      if (cnt < 11'd128)       m_bit = key_r[cnt[6:0]];
      else if (cnt < 11'd256)  m_bit = iv_r[cnt[6:0]];
      else if (cnt == 11'd256) m_bit = ~key_r[0];
      else                     m_bit = key_r[cnt[6:0]];
    end else if (st == READY) begin
      m_bit = m_in;
    end
  end

  assign in_ready = (st == READY);
  assign busy     = (st == INIT);
  assign ca_out   = (st == INIT) | ((st == READY) & ca_in);
  assign cb_out   = (st == INIT) | ((st == READY) & cb_in);
  assign s_next   = {f_in ^ m_bit, state_out[292:1]};

  // A restart in READY takes priority over a coincident message step.
  assign do_step  = (st == INIT) || ((st == READY) && in_valid && !start);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      s         <= '0;
      cnt       <= '0;
      key_r     <= '0;
      iv_r      <= '0;
      init_done <= 1'b0;
      step      <= 1'b0;
    end else begin
      step      <= do_step;
      init_done <= 1'b0;
      case (st)
        INIT: begin
          s <= s_next;
          if (cnt == 11'd1791) begin
            st        <= READY;
            init_done <= 1'b1;
`ifdef ACORN_KEY_ZEROIZE_EN
            key_r     <= '0;
`endif
          end else begin
            cnt <= cnt + 11'd1;
          end
        end
        IDLE, READY: begin
          if (start) begin
            st    <= INIT;
            s     <= '0;
            cnt   <= '0;
            key_r <= key;
            iv_r  <= iv;
          end else if (do_step) begin
            s <= s_next;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acorn128_state_reg.sv
// Bench for acorn128_state_reg: closes the feedback loop with the ACORN-128 f function and checks against a bit-level model.
module tb_acorn128_state_reg;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [127:0] iv;
  logic         f_in;
  logic         m_in;
  logic         ca_in;
  logic         cb_in;
  logic         in_valid;
  logic         in_ready;
  logic [292:0] state_out;
  logic         ca_out;
  logic         cb_out;
  logic         busy;
  logic         init_done;
  logic         step;

  acorn128_state_reg dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv), .f_in(f_in),
    .m_in(m_in), .ca_in(ca_in), .cb_in(cb_in), .in_valid(in_valid),
    .in_ready(in_ready), .state_out(state_out), .ca_out(ca_out), .cb_out(cb_out),
    .busy(busy), .init_done(init_done), .step(step)
  );

  always #5 clk = ~clk;

  localparam int TAPS [6][3] = '{'{289, 235, 230}, '{230, 196, 193}, '{193, 160, 154},
                                 '{154, 111, 107}, '{107, 66, 61},   '{61, 23, 0}};

  int checks = 0;
  int errors = 0;
  bit [292:0] ms;
  bit [127:0] mk;
  bit [127:0] miv;
  bit [292:0] golden;

  function automatic bit maj(bit x, bit y, bit z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic bit ch(bit x, bit y, bit z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic bit fb(bit [292:0] u, bit ca, bit cb);
    bit ks;
    ks = u[12] ^ u[154] ^ maj(u[235], u[61], u[193]) ^ ch(u[230], u[111], u[66]);
    return u[0] ^ ~u[107] ^ maj(u[244], u[23], u[160]) ^ (ca & u[196]) ^ (cb & ks);
  endfunction

  function automatic bit [292:0] lfsr(bit [292:0] s);
    bit [292:0] u = s;
    for (int k = 0; k < 6; k++) u[TAPS[k][0]] = u[TAPS[k][0]] ^ u[TAPS[k][1]] ^ u[TAPS[k][2]];
    return u;
  endfunction

  function automatic bit [292:0] mstep(bit [292:0] s, bit m, bit ca, bit cb);
    bit [292:0] u = lfsr(s);
    bit [292:0] n;
    for (int j = 0; j < 292; j++) n[j] = u[j + 1];
    n[292] = fb(u, ca, cb) ^ m;
    return n;
  endfunction

  function automatic bit init_m(int i, bit [127:0] k, bit [127:0] v);
    if (i < 128) return k[i];
    if (i < 256) return v[i - 128];
    if (i == 256) return ~k[0];
    return k[i % 128];
  endfunction

  assign f_in = fb(state_out, ca_out, cb_out);

  task automatic chk(input string nm, input logic [292:0] act, input logic [292:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit [127:0] k, input bit [127:0] v);
    key = k; iv = v; start = 1'b1;
    ms = '0; mk = k; miv = v;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_zero", state_out, '0);
  endtask

  task automatic finish_init(input bit order_chk);
    bit fprev;
    for (int i = 0; i < 1792; i++) begin
      fprev = f_in;
      ms = mstep(ms, init_m(i, mk, miv), 1'b1, 1'b1);
      tick();
      if (order_chk && i == 0)   chk("order_first", state_out[292], fprev ^ 1'b1);
      if (order_chk && i == 256) chk("order_256", state_out[292], fprev);
      if (i == 1790) begin
        chk("init_busy_1791", busy, 1'b1);
        chk("init_done_early", init_done, 1'b0);
      end
    end
    chk("init_done", init_done, 1'b1);
    chk("init_ready", in_ready, 1'b1);
    chk("init_busy_end", busy, 1'b0);
    chk("init_state", state_out, lfsr(ms));
  endtask

  typedef struct {
    bit vld; bit st; bit m; bit ca; bit cb;
    bit exp_step; bit exp_busy; bit exp_rdy;
  } vec_t;

  initial begin
    vec_t tbl [4];
    bit [127:0] rk;
    bit [127:0] rv;
    bit v, m, ca, cb;

    tbl[0] = '{1, 0, 1, 1, 0, 1, 0, 1};
    tbl[1] = '{0, 0, 1, 1, 0, 0, 0, 1};
    tbl[2] = '{1, 0, 1, 1, 0, 1, 0, 1};
    tbl[3] = '{1, 1, 1, 1, 0, 0, 1, 0};

    rst = 1'b1; start = 1'b0; key = '0; iv = '0;
    m_in = 1'b0; ca_in = 1'b0; cb_in = 1'b0; in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_state", state_out, '0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", init_done, 1'b0);
    chk("rst_step", step, 1'b0);
    chk("rst_ca", ca_out, 1'b0);
    chk("rst_cb", cb_out, 1'b0);

    // All-zero key/IV golden run.
    do_start('0, '0);
    finish_init(1'b0);
    golden = state_out;

    // Reset in the middle of INIT, then rerun.
    do_start('0, '0);
    repeat (500) tick();
    rst = 1'b1;
    #1;
    chk("midrst_state", state_out, '0);
    chk("midrst_busy", busy, 1'b0);
    tick();
    chk("midrst_state2", state_out, '0);
    chk("midrst_ready", in_ready, 1'b0);
    chk("midrst_step", step, 1'b0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 1'b0);
    do_start('0, '0);
    finish_init(1'b0);
    chk("rerun_golden", state_out, golden);

    // Key bit order.
    do_start(128'h1, '0);
    finish_init(1'b1);

    // READY handshake table; last row restarts with a coincident in_valid.
    rk = {$urandom, $urandom, $urandom, $urandom};
    rv = {$urandom, $urandom, $urandom, $urandom};
    for (int r = 0; r < 4; r++) begin
      in_valid = tbl[r].vld; start = tbl[r].st; m_in = tbl[r].m;
      ca_in = tbl[r].ca; cb_in = tbl[r].cb; key = rk; iv = rv;
      #1;
      chk("hs_ca", ca_out, 1'b1);
      chk("hs_cb", cb_out, 1'b0);
      if (tbl[r].st) begin
        ms = '0; mk = rk; miv = rv;
      end else if (tbl[r].vld) begin
        ms = mstep(ms, tbl[r].m, tbl[r].ca, tbl[r].cb);
      end
      tick();
      chk("hs_step", step, tbl[r].exp_step);
      chk("hs_busy", busy, tbl[r].exp_busy);
      chk("hs_ready", in_ready, tbl[r].exp_rdy);
      chk("hs_done", init_done, 1'b0);
      chk("hs_state", state_out, lfsr(ms));
    end
    in_valid = 1'b0; start = 1'b0;
    finish_init(1'b0);
`ifdef ACORN_KEY_ZEROIZE_EN
    chk("key_zeroized", dut.key_r, '0);
`else
    chk("key_retained", dut.key_r, rk);
`endif

    // Randomized READY traffic.
    for (int n = 0; n < 300; n++) begin
      v = 1'($urandom); m = 1'($urandom); ca = 1'($urandom); cb = 1'($urandom);
      in_valid = v; m_in = m; ca_in = ca; cb_in = cb;
      #1;
      if (v) ms = mstep(ms, m, ca, cb);
      tick();
      chk("rnd_state", state_out, lfsr(ms));
      chk("rnd_step", step, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acorn128_state_reg.md
# acorn128_state_reg

Holds the 293-bit ACORN-128 state and performs one state-update step per accepted clock. Its companion stage is the feedback stage, which returns the bit f. The block owns the key/IV initialization schedule: 1792 self-driven steps, after which it hands stepping control to the upstream message sequencer through a valid/ready handshake. It drives `state_out`, `ca_out` and `cb_out` to the feedback stage, and shifts in the returned f combined with the message bit.

## Interface
- No parameters; the state width of 293 and the init length of 1792 are fixed by the cipher.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse that loads `key`/`iv`, zeroes the state and begins INIT; ignored unless in IDLE or READY
- key  in  128  key; bit 0 is consumed first
- iv  in  128  IV; bit 0 is consumed first
- f_in  in  1  feedback bit; combinational function of `state_out`, `ca_out`, `cb_out` in the same cycle
- m_in  in  1  message bit (READY phase)
- ca_in  in  1  control bit ca (READY phase)
- cb_in  in  1  control bit cb (READY phase)
- in_valid  in  1  upstream step request (READY phase)
- in_ready  out  1  high only in READY
- state_out  out  293  LFSR-updated state, pre-shift (see Operation)
- ca_out  out  1  active ca value
- cb_out  out  1  active cb value
- busy  out  1  high in INIT
- init_done  out  1  one-cycle pulse after the last INIT step
- step  out  1  registered pulse, high the cycle after each state shift

## Operation
- Register S[292:0]. `state_out` = S with the six LFSR updates applied combinationally, in order:
  - s289^=s235^s230
  - s230^=s196^s193
  - s193^=s160^s154
  - s154^=s111^s107
  - s107^=s66^s61
  - s61^=s23^s0
- Shift on step: S <= {f_in ^ m, state_out[292:1]}.
- FSM states: IDLE, INIT, READY.
- IDLE:
  - S holds its value; `in_ready`=0, `busy`=0.
  - `start` → INIT, with S<=0, key/IV latched and 11-bit counter i<=0.
- INIT (one step every cycle, i = 0..1791):
  - m = key[i] for i<128.
  - m = iv[i-128] for 128≤i<256.
  - m = key[0]^1 for i=256.
  - m = key[i mod 128] for i>256.
  - ca_out=cb_out=1.
  - At i=1791, step then go to READY; `init_done` pulses the following cycle.
- READY:
  - ca_out=ca_in, cb_out=cb_in, m=m_in.
  - A step occurs iff in_valid && in_ready.
  - With no step, S holds.
- `start` in READY: restarts INIT with fresh key/IV and S<=0; a coincident in_valid is dropped (no step).
- `start` in INIT: ignored.
- Reset (any time, including mid-INIT):
  - S=0, state IDLE, counter 0, key/IV registers 0.
  - Outputs: in_ready=0, busy=0, init_done=0, step=0, ca_out=0, cb_out=0.
  - state_out=0, since the LFSR updates of a zero state are zero.

## Timing
- One step per clock. The next-state update uses the same-cycle `f_in`, so there is no bubble.
- start accepted at edge 0:
  - busy=1 from edge 0 through the last INIT step at edge 1792.
  - READY and init_done=1 after edge 1792.
  - in_ready=1 from that cycle on.
- step latency: `step` is high the cycle after the edge that shifted S.
- Counter is 11 bits and never wraps; the terminal compare is at 1791.

## Configuration
- `ACORN_KEY_ZEROIZE_EN` defined:
  - The latched key register is cleared to 0 on the edge that completes INIT.
  - While that macro is defined, a `start` in READY uses the current `key` port value.
- Not defined: the latched key is retained until the next `start` or reset.
- No other behaviour differs.

## Test plan
- Reset mid-INIT: assert rst at step 500 → next cycle state_out=0, busy=0, in_ready=0; `start` then rerunning full INIT reproduces the golden state.
- All-zero key and IV, f_in from the golden feedback model:
  - init_done asserts exactly 1793 cycles after start.
  - state_out equals the ACORN-128 reference-model state after 1792 steps.
- Key bit-order check: key=128'h1, iv=0 → first INIT step shifts f^1 into bit 292; step 256 uses m=0.
- READY handshake:
  - in_valid toggling 1,0,1 with m_in=1, ca_in=1, cb_in=0 → exactly two shifts, two step pulses, S unchanged on the idle cycle.
  - ca_out=1, cb_out=0 throughout.
- `start` coincident with in_valid in READY → no message step, S=0, busy=1 next cycle.
- Zeroize, macro defined: internal key register reads 0 after init_done.
- Zeroize, macro not defined: internal key register equals the loaded key after init_done.
